// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b processed LSB-first through one full-subtractor cell.
// Operands and results move through valid/ready handshakes; diff/borrow are registered outputs.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bor_q, bor_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             bit_d;
    logic             bit_bor;
    logic [WIDTH:0]   diff_ext;

    always_comb begin
        bit_d    = a_sh_q[0] ^ b_sh_q[0] ^ bor_q;
        bit_bor  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & bor_q);
        // Extended vector lets the MSB insertion work for WIDTH = 1 as well.
        diff_ext = {bit_d, diff_sh_q};

        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        diff_sh_d = diff_sh_q;
        diff_d    = diff_q;
        bor_d     = bor_q;
        borrow_d  = borrow_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    bor_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d    = a_sh_q >> 1;
                b_sh_d    = b_sh_q >> 1;
                diff_sh_d = diff_ext[WIDTH:1];
                bor_d     = bit_bor;
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d   = diff_ext[WIDTH:1];
                    borrow_d = bit_bor;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            diff_sh_q <= '0;
            diff_q    <= '0;
            bor_q     <= 1'b0;
            borrow_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            diff_sh_q <= diff_sh_d;
            diff_q    <= diff_d;
            bor_q     <= bor_d;
            borrow_q  <= borrow_d;
            cnt_q     <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 and WIDTH=2 instances checked against
// plain modular arithmetic with randomized operands and handshake disturbance.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a_bus;
    logic [7:0] b_bus;
    logic       sel2;

    logic       in_ready8, out_valid8, borrow8, busy8;
    logic [7:0] diff8;
    logic       in_ready2, out_valid2, borrow2, busy2;
    logic [1:0] diff2;

    logic        obs_in_ready, obs_out_valid, obs_borrow, obs_busy;
    logic [31:0] obs_diff;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid & ~sel2),
        .in_ready (in_ready8),
        .a        (a_bus),
        .b        (b_bus),
        .out_valid(out_valid8),
        .out_ready(out_ready),
        .diff     (diff8),
        .borrow   (borrow8),
        .busy     (busy8)
    );

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid & sel2),
        .in_ready (in_ready2),
        .a        (a_bus[1:0]),
        .b        (b_bus[1:0]),
        .out_valid(out_valid2),
        .out_ready(out_ready),
        .diff     (diff2),
        .borrow   (borrow2),
        .busy     (busy2)
    );

    always_comb begin
        obs_in_ready  = sel2 ? in_ready2  : in_ready8;
        obs_out_valid = sel2 ? out_valid2 : out_valid8;
        obs_borrow    = sel2 ? borrow2    : borrow8;
        obs_busy      = sel2 ? busy2      : busy8;
        obs_diff      = sel2 ? {30'd0, diff2} : {24'd0, diff8};
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One full transaction; entered and left #1 after a rising edge with the DUT idle.
    task automatic run_txn(input bit w2, input logic [7:0] av, input logic [7:0] bv,
                           input int hold, output int valid_cyc);
        int unsigned w;
        logic [31:0] mask, ea, eb, exp_diff, exp_bor;
        int n;
        sel2 = w2;
        w    = w2 ? 2 : 8;
        mask = (32'd1 << w) - 32'd1;
        ea   = {24'd0, av} & mask;
        eb   = {24'd0, bv} & mask;
        exp_diff = (ea - eb) & mask;
        exp_bor  = (ea < eb) ? 32'd1 : 32'd0;

        a_bus = av; b_bus = bv; in_valid = 1'b1; out_ready = (hold == 0);
        check_eq("in_ready_idle", {31'd0, obs_in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("busy_run", {31'd0, obs_busy}, 32'd1);
        n = 0;
        while (!obs_out_valid && n < 40) begin
            a_bus = 8'($urandom); b_bus = 8'($urandom);
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        in_valid  = 1'b0;
        valid_cyc = cyc;
        check_eq("latency", n, w);
        check_eq("diff", obs_diff, exp_diff);
        check_eq("borrow", {31'd0, obs_borrow}, exp_bor);

        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            a_bus = 8'($urandom); b_bus = 8'($urandom);
            @(posedge clk); #1;
            check_eq("bp_out_valid", {31'd0, obs_out_valid}, 32'd1);
            check_eq("bp_in_ready", {31'd0, obs_in_ready}, 32'd0);
            check_eq("bp_diff", obs_diff, exp_diff);
            check_eq("bp_borrow", {31'd0, obs_borrow}, exp_bor);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("out_valid_pulse", {31'd0, obs_out_valid}, 32'd0);
        check_eq("in_ready_back", {31'd0, obs_in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc, prev_vc;
        logic [7:0] ra, rb;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a_bus = '0; b_bus = '0; sel2 = 1'b0;
        #12;
        check_eq("rst_in_ready", {31'd0, in_ready8}, 32'd1);
        check_eq("rst_out_valid", {31'd0, out_valid8}, 32'd0);
        check_eq("rst_busy", {31'd0, busy8}, 32'd0);
        check_eq("rst_diff", {24'd0, diff8}, 32'd0);
        check_eq("rst_borrow", {31'd0, borrow8}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(1'b0, 8'h05, 8'h03, 0, vc);
        run_txn(1'b0, 8'h03, 8'h05, 0, vc);
        run_txn(1'b0, 8'h00, 8'h01, 0, vc);
        run_txn(1'b0, 8'hFF, 8'hFF, 0, vc);
        run_txn(1'b0, 8'h80, 8'h7F, 0, vc);
        run_txn(1'b0, 8'h00, 8'hFF, 5, vc);
        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            run_txn(1'b0, ra, rb, int'($urandom_range(0, 2)), vc);
        end
        run_txn(1'b0, 8'h01, 8'hC3, 0, vc);

        // Abort while bit 3 is being processed; previous diff is nonzero.
        sel2 = 1'b0; a_bus = 8'h5A; b_bus = 8'h33; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("abort_in_ready", {31'd0, in_ready8}, 32'd1);
        check_eq("abort_out_valid", {31'd0, out_valid8}, 32'd0);
        check_eq("abort_busy", {31'd0, busy8}, 32'd0);
        check_eq("abort_diff", {24'd0, diff8}, 32'd0);
        check_eq("abort_borrow", {31'd0, borrow8}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn(1'b0, 8'h10, 8'h01, 0, vc);

        prev_vc = 0;
        for (int ia = 0; ia < 4; ia++) begin
            for (int ib = 0; ib < 4; ib++) begin
                run_txn(1'b1, 8'(ia), 8'(ib), 0, vc);
                if (ia != 0 || ib != 0) check_eq("w2_spacing", vc - prev_vc, 4);
                prev_vc = vc;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
